// File: rtl/cgia_fetcher_pkg.sv
// Shared CGIA width constants for the video DMA fetcher.
package cgia_fetcher_pkg;

    localparam int unsigned ADR_W = 23;
    localparam int unsigned LEN_W = 9;
    localparam int unsigned DAT_W = 16;

endpackage

// File: rtl/cgia_fetcher.sv
// CGIA video DMA fetcher: one Wishbone burst per HSYNC fills a ping-pong line buffer.
module cgia_fetcher
    import cgia_fetcher_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             den_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [ADR_W-1:0] fb_adr_i,
    input  logic [LEN_W-1:0] line_len_i,
    input  logic             ack_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic             cyc_o,
    output logic [ADR_W-1:0] adr_o,
    output logic             lb_we_o,
    output logic             lb_sel_o,
    output logic [LEN_W-1:0] lb_adr_o,
    output logic [DAT_W-1:0] lb_dat_o
);

    logic [ADR_W-1:0] ptr_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] idx_q;
    logic             busy_q;
    logic             sel_q;
    logic             trig_q;

    logic trig;
    logic start;
    logic beat;

    assign trig  = hsync_i & den_i;
    assign start = trig & ~trig_q & ~busy_q & (line_len_i != '0);
    assign beat  = busy_q & ack_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            sel_q  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            // Edge history tracks the trigger even while VSYNC suppresses starts.
            trig_q <= trig;
            if (vsync_i) begin
                ptr_q  <= fb_adr_i;
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= line_len_i;
                idx_q  <= '0;
            end else if (beat) begin
                ptr_q <= ptr_q + ADR_W'(1);
                idx_q <= idx_q + LEN_W'(1);
                cnt_q <= cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    busy_q <= 1'b0;
                    sel_q  <= ~sel_q;
                end
            end
        end
    end

    assign cyc_o    = busy_q;
    assign adr_o    = ptr_q;
    assign lb_we_o  = beat;
    assign lb_sel_o = sel_q;
    assign lb_adr_o = idx_q;
    assign lb_dat_o = dat_i;

endmodule

// File: tb/tb_cgia_fetcher.sv
// Self-checking bench for cgia_fetcher: directed scenarios plus randomized lines vs. a line-level model.
module tb_cgia_fetcher;
    import cgia_fetcher_pkg::*;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             den_i = 1'b0;
    logic             hsync_i = 1'b0;
    logic             vsync_i = 1'b0;
    logic [ADR_W-1:0] fb_adr_i = '0;
    logic [LEN_W-1:0] line_len_i = '0;
    logic             ack_i = 1'b0;
    logic [DAT_W-1:0] dat_i = '0;
    logic             cyc_o;
    logic [ADR_W-1:0] adr_o;
    logic             lb_we_o;
    logic             lb_sel_o;
    logic [LEN_W-1:0] lb_adr_o;
    logic [DAT_W-1:0] lb_dat_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: where the next word comes from and which buffer it lands in.
    logic [ADR_W-1:0] m_ptr = '0;
    logic             m_sel = 1'b0;

    cgia_fetcher dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .den_i      (den_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .fb_adr_i   (fb_adr_i),
        .line_len_i (line_len_i),
        .ack_i      (ack_i),
        .dat_i      (dat_i),
        .cyc_o      (cyc_o),
        .adr_o      (adr_o),
        .lb_we_o    (lb_we_o),
        .lb_sel_o   (lb_sel_o),
        .lb_adr_o   (lb_adr_o),
        .lb_dat_o   (lb_dat_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change at the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; ack_i = 1'b1; hsync_i = 1'b1; den_i = 1'b1;
        step(); step();
        #1;
        n_tests++;
        if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b want 0", cyc_o); end
        n_tests++;
        if (adr_o !== '0) begin n_fail++; $display("FAIL reset_adr got %h want 0", adr_o); end
        n_tests++;
        if (lb_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", lb_we_o); end
        step();
        reset_i = 1'b0; hsync_i = 1'b0; den_i = 1'b0; ack_i = 1'b0;
        step();
        #1;
        n_tests++;
        if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_cyc got %b want 0", cyc_o); end
        m_ptr = '0;
        m_sel = 1'b0;
    endtask

    task automatic load_vsync(input logic [ADR_W-1:0] base);
        step();
        fb_adr_i = base; vsync_i = 1'b1;
        step();
        vsync_i = 1'b0;
        #1;
        m_ptr = base;
        n_tests++;
        if (adr_o !== base) begin
            n_fail++; $display("FAIL vsync_load got %h want %h", adr_o, base);
        end
    endtask

    task automatic test_vsync_load();
        load_vsync(23'(24'hFF0000 >> 1));
        den_i = 1'b0; hsync_i = 1'b1; line_len_i = 9'd6;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_tests++;
            if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL no_den_start got %b want 0", cyc_o); end
        end
        step();
        hsync_i = 1'b0;
    endtask

    // One line fetched through the bus; waits >0 inserts random wait states.
    task automatic run_line(input int len, input int wait_pct);
        int beats;
        int cycles;
        logic a;
        logic [DAT_W-1:0] d;
        step();
        line_len_i = LEN_W'(len);
        hsync_i = 1'b1; den_i = 1'b1; ack_i = 1'($urandom);
        #1;
        n_tests++;
        if (lb_we_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_before_line got cyc=%b we=%b want 0/0", cyc_o, lb_we_o);
        end
        beats = 0;
        cycles = 0;
        while (beats < len && cycles < 4 * len + 20) begin
            step();
            hsync_i = 1'($urandom);
            den_i = 1'($urandom);
            line_len_i = LEN_W'($urandom);
            a = ($urandom_range(99) >= wait_pct) ? 1'b1 : 1'b0;
            d = DAT_W'($urandom);
            ack_i = a; dat_i = d;
            #1;
            n_tests++;
            if (cyc_o !== 1'b1 || adr_o !== m_ptr || lb_we_o !== a) begin
                n_fail++;
                $display("FAIL line_bus beat %0d got cyc=%b adr=%h we=%b want 1/%h/%b",
                         beats, cyc_o, adr_o, lb_we_o, m_ptr, a);
            end
            if (a) begin
                n_tests++;
                if (lb_adr_o !== LEN_W'(beats) || lb_sel_o !== m_sel || lb_dat_o !== d) begin
                    n_fail++;
                    $display("FAIL line_write got idx=%0d sel=%b dat=%h want %0d/%b/%h",
                             lb_adr_o, lb_sel_o, lb_dat_o, beats, m_sel, d);
                end
                beats++;
                m_ptr = m_ptr + 1'b1;
            end
            cycles++;
        end
        n_tests++;
        if (beats != len) begin
            n_fail++; $display("FAIL line_timeout got %0d beats want %0d", beats, len);
        end
        m_sel = ~m_sel;
        step();
        hsync_i = 1'b0; ack_i = 1'b1;
        #1;
        n_tests++;
        if (cyc_o !== 1'b0 || lb_we_o !== 1'b0 || lb_sel_o !== m_sel || adr_o !== m_ptr) begin
            n_fail++;
            $display("FAIL line_end got cyc=%b we=%b sel=%b adr=%h want 0/0/%b/%h",
                     cyc_o, lb_we_o, lb_sel_o, adr_o, m_sel, m_ptr);
        end
        step(); #1;
        n_tests++;
        if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL line_idle got %b want 0", cyc_o); end
        ack_i = 1'b0;
    endtask

    task automatic test_line();
        run_line(6, 0);
        n_tests++;
        if (m_ptr !== 23'(24'hFF000C >> 1)) begin
            n_fail++; $display("FAIL line_final_ptr got %h want %h", m_ptr, 23'(24'hFF000C >> 1));
        end
    endtask

    task automatic test_wait_states();
        logic [ADR_W-1:0] held;
        step();
        line_len_i = 9'd4; hsync_i = 1'b1; den_i = 1'b1; ack_i = 1'b1;
        step();
        hsync_i = 1'b0;
        step();
        ack_i = 1'b0;
        held = m_ptr + 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_tests++;
            if (cyc_o !== 1'b1 || adr_o !== held || lb_we_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold got cyc=%b adr=%h we=%b want 1/%h/0",
                         cyc_o, adr_o, lb_we_o, held);
            end
        end
        ack_i = 1'b1;
        step(); #1;
        n_tests++;
        if (adr_o !== held + 1'b1 || lb_adr_o !== 9'd2) begin
            n_fail++;
            $display("FAIL wait_resume got adr=%h idx=%0d want %h/2", adr_o, lb_adr_o, held + 1'b1);
        end
        step(); step();
        ack_i = 1'b0;
        #1;
        m_ptr = m_ptr + 23'd4;
        m_sel = ~m_sel;
        n_tests++;
        if (cyc_o !== 1'b0 || adr_o !== m_ptr || lb_sel_o !== m_sel) begin
            n_fail++;
            $display("FAIL wait_end got cyc=%b adr=%h sel=%b want 0/%h/%b",
                     cyc_o, adr_o, lb_sel_o, m_ptr, m_sel);
        end
    endtask

    task automatic test_vsync_abort();
        logic [ADR_W-1:0] nb;
        nb = ADR_W'($urandom);
        step();
        line_len_i = 9'd8; hsync_i = 1'b1; den_i = 1'b1; ack_i = 1'b1;
        step();
        hsync_i = 1'b0;
        step();
        fb_adr_i = nb; vsync_i = 1'b1;
        step();
        hsync_i = 1'b1;
        #1;
        n_tests++;
        if (cyc_o !== 1'b0 || adr_o !== nb) begin
            n_fail++; $display("FAIL vsync_abort got cyc=%b adr=%h want 0/%h", cyc_o, adr_o, nb);
        end
        step(); #1;
        n_tests++;
        if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL vsync_blocks_start got %b want 0", cyc_o); end
        vsync_i = 1'b0; hsync_i = 1'b0; ack_i = 1'b0;
        m_ptr = nb;
    endtask

    task automatic test_zero_len();
        step();
        line_len_i = '0; hsync_i = 1'b1; den_i = 1'b1; ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_tests++;
            if (cyc_o !== 1'b0 || adr_o !== m_ptr) begin
                n_fail++; $display("FAIL zero_len got cyc=%b adr=%h want 0/%h", cyc_o, adr_o, m_ptr);
            end
        end
        hsync_i = 1'b0; ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_line(int'($urandom_range(24, 1)), 40);
        end
        load_vsync(23'h7FFFFD);
        run_line(7, 30);
        run_line(3, 0);
    endtask

    initial begin
        test_reset();
        test_vsync_load();
        test_line();
        run_line(6, 0);
        test_wait_states();
        test_vsync_abort();
        run_line(5, 25);
        test_zero_len();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
